// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one registered ALU between two requesters.
// Holds the winner's operands on the ALU for its latency, then returns a tagged response.
module alu_arbiter #(
   parameter int NUMBITS = 16,
   parameter int ALU_LAT = 1,
   parameter int CNTBITS = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req0_valid,
   output logic               req0_ready,
   input  logic [NUMBITS-1:0] req0_a,
   input  logic [NUMBITS-1:0] req0_b,
   input  logic [2:0]         req0_op,
   input  logic               req1_valid,
   output logic               req1_ready,
   input  logic [NUMBITS-1:0] req1_a,
   input  logic [NUMBITS-1:0] req1_b,
   input  logic [2:0]         req1_op,
   output logic [NUMBITS-1:0] alu_a,
   output logic [NUMBITS-1:0] alu_b,
   output logic [2:0]         alu_opcode,
   input  logic [NUMBITS-1:0] alu_result,
   input  logic               alu_carryout,
   input  logic               alu_overflow,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic               rsp_id,
   output logic [NUMBITS-1:0] rsp_result,
   output logic               rsp_carryout,
   output logic               rsp_overflow,
   output logic               rsp_zero,
   output logic [CNTBITS-1:0] done_cnt0,
   output logic [CNTBITS-1:0] done_cnt1
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic [2:0]         LAT_LAST = 3'(ALU_LAT);
   localparam logic [CNTBITS-1:0] CNT_ONE  = 1;

   state_t               state_q, state_d;
   logic                 last_grant_q, last_grant_d;
   logic [2:0]           lat_cnt_q, lat_cnt_d;
   logic [NUMBITS-1:0]   op_a_q, op_a_d;
   logic [NUMBITS-1:0]   op_b_q, op_b_d;
   logic [2:0]           op_code_q, op_code_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic                 rsp_id_q, rsp_id_d;
   logic [NUMBITS-1:0]   rsp_result_q, rsp_result_d;
   logic                 rsp_carry_q, rsp_carry_d;
   logic                 rsp_ovf_q, rsp_ovf_d;
   logic                 rsp_zero_q, rsp_zero_d;
   logic [CNTBITS-1:0]   done_cnt0_q, done_cnt0_d;
   logic [CNTBITS-1:0]   done_cnt1_q, done_cnt1_d;
   logic                 grant_id;

   // With both requesters pending, the one that did not win last time goes next.
   assign grant_id = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_d      = state_q;
      last_grant_d = last_grant_q;
      lat_cnt_d    = lat_cnt_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      op_code_d    = op_code_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_carry_d  = rsp_carry_q;
      rsp_ovf_d    = rsp_ovf_q;
      rsp_zero_d   = rsp_zero_q;
      done_cnt0_d  = done_cnt0_q;
      done_cnt1_d  = done_cnt1_q;
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;

      case (state_q)
         IDLE: begin
            req0_ready = req0_valid & ~grant_id;
            req1_ready = req1_valid & grant_id;
            if (req0_valid || req1_valid) begin
               op_a_d       = grant_id ? req1_a  : req0_a;
               op_b_d       = grant_id ? req1_b  : req0_b;
               op_code_d    = grant_id ? req1_op : req0_op;
               last_grant_d = grant_id;
               lat_cnt_d    = '0;
               state_d      = EXEC;
            end
         end
         EXEC: begin
            lat_cnt_d = lat_cnt_q + 3'd1;
            if (lat_cnt_q == LAT_LAST) begin
               rsp_result_d = alu_result;
               rsp_carry_d  = alu_carryout;
               rsp_ovf_d    = alu_overflow;
               rsp_zero_d   = (alu_result == '0);
               rsp_id_d     = last_grant_q;
               rsp_valid_d  = 1'b1;
               state_d      = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               if (rsp_id_q) done_cnt1_d = done_cnt1_q + CNT_ONE;
               else          done_cnt0_d = done_cnt0_q + CNT_ONE;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         lat_cnt_q    <= '0;
         op_a_q       <= '0;
         op_b_q       <= '0;
         op_code_q    <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
         rsp_carry_q  <= 1'b0;
         rsp_ovf_q    <= 1'b0;
         rsp_zero_q   <= 1'b0;
         done_cnt0_q  <= '0;
         done_cnt1_q  <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         lat_cnt_q    <= lat_cnt_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         op_code_q    <= op_code_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_carry_q  <= rsp_carry_d;
         rsp_ovf_q    <= rsp_ovf_d;
         rsp_zero_q   <= rsp_zero_d;
         done_cnt0_q  <= done_cnt0_d;
         done_cnt1_q  <= done_cnt1_d;
      end
   end

   assign alu_a        = op_a_q;
   assign alu_b        = op_b_q;
   assign alu_opcode   = op_code_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_id       = rsp_id_q;
   assign rsp_result   = rsp_result_q;
   assign rsp_carryout = rsp_carry_q;
   assign rsp_overflow = rsp_ovf_q;
   assign rsp_zero     = rsp_zero_q;
   assign done_cnt0    = done_cnt0_q;
   assign done_cnt1    = done_cnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a cycle-level transaction model checks a latency-1 instance,
// and a latency-3 instance with 2-bit counters covers long latency and counter wrap.
module tb_alu_arbiter;

   localparam int LAT = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Latency-1 instance
   logic        reset;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [15:0] req0_a, req0_b, req1_a, req1_b;
   logic [2:0]  req0_op, req1_op;
   logic [15:0] alu_a, alu_b, alu_result;
   logic [2:0]  alu_opcode;
   logic        alu_carryout, alu_overflow;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_carryout, rsp_overflow, rsp_zero;
   logic [15:0] rsp_result, done_cnt0, done_cnt1;

   // Latency-3 instance with 2-bit counters
   logic        w_reset;
   logic        w_req0_valid, w_req0_ready, w_req1_valid, w_req1_ready;
   logic [15:0] w_req0_a, w_req0_b, w_req1_a, w_req1_b;
   logic [2:0]  w_req0_op, w_req1_op;
   logic [15:0] w_alu_a, w_alu_b, w_alu_result;
   logic [2:0]  w_alu_opcode;
   logic        w_alu_carryout, w_alu_overflow;
   logic        w_rsp_valid, w_rsp_ready, w_rsp_id, w_rsp_carryout, w_rsp_overflow, w_rsp_zero;
   logic [15:0] w_rsp_result;
   logic [1:0]  w_done_cnt0, w_done_cnt1;

   alu_arbiter #(.NUMBITS(16), .ALU_LAT(LAT), .CNTBITS(16)) u_dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
      .alu_result(alu_result), .alu_carryout(alu_carryout), .alu_overflow(alu_overflow),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
      .rsp_carryout(rsp_carryout), .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero),
      .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
   );

   alu_arbiter #(.NUMBITS(16), .ALU_LAT(3), .CNTBITS(2)) u_dut_w (
      .clk(clk), .reset(w_reset),
      .req0_valid(w_req0_valid), .req0_ready(w_req0_ready), .req0_a(w_req0_a), .req0_b(w_req0_b), .req0_op(w_req0_op),
      .req1_valid(w_req1_valid), .req1_ready(w_req1_ready), .req1_a(w_req1_a), .req1_b(w_req1_b), .req1_op(w_req1_op),
      .alu_a(w_alu_a), .alu_b(w_alu_b), .alu_opcode(w_alu_opcode),
      .alu_result(w_alu_result), .alu_carryout(w_alu_carryout), .alu_overflow(w_alu_overflow),
      .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready), .rsp_id(w_rsp_id), .rsp_result(w_rsp_result),
      .rsp_carryout(w_rsp_carryout), .rsp_overflow(w_rsp_overflow), .rsp_zero(w_rsp_zero),
      .done_cnt0(w_done_cnt0), .done_cnt1(w_done_cnt1)
   );

   // Behavioural ALU: returns {carry, overflow, result}
   function automatic logic [17:0] alu_fn(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
      logic [16:0] s;
      logic        c, v;
      logic [15:0] r;
      c = 1'b0;
      v = 1'b0;
      case (op)
         3'b000, 3'b001: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[15:0]; c = s[16];
            v = (a[15] == b[15]) && (r[15] != a[15]);
         end
         3'b010, 3'b011: begin
            s = {1'b0, a} - {1'b0, b};
            r = s[15:0]; c = s[16];
            v = (a[15] != b[15]) && (r[15] != a[15]);
         end
         3'b100:  r = a & b;
         3'b101:  r = a | b;
         3'b110:  r = a ^ b;
         default: r = ~(a | b);
      endcase
      return {c, v, r};
   endfunction

   logic [17:0] pipe1;
   logic [17:0] pipe3 [3];
   always @(posedge clk) begin
      pipe1    <= alu_fn(alu_a, alu_b, alu_opcode);
      pipe3[0] <= alu_fn(w_alu_a, w_alu_b, w_alu_opcode);
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
   end
   assign {alu_carryout, alu_overflow, alu_result}       = pipe1;
   assign {w_alu_carryout, w_alu_overflow, w_alu_result} = pipe3[2];

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Transaction model: one op in flight, response due LAT+2 cycles after accept
   int          cyc = 0;
   int          m_acc_cyc;
   logic        m_busy, m_last, m_id;
   logic [15:0] m_a, m_b;
   logic [2:0]  m_op;
   logic [17:0] m_exp;
   logic [15:0] m_cnt0, m_cnt1;
   logic        drop_on_accept = 1'b0;
   bit          obs_q [$];
   logic [15:0] last_res;
   logic        last_c, last_v, last_z, last_id;
   int          last_lat;

   task automatic step();
      logic e_r0, e_r1, e_rv;
      e_r0 = 1'b0; e_r1 = 1'b0; e_rv = 1'b0;
      @(negedge clk);
      if (!reset) begin
         e_r0 = !m_busy && req0_valid && (!req1_valid || m_last);
         e_r1 = !m_busy && req1_valid && (!req0_valid || !m_last);
         e_rv = m_busy && (cyc >= m_acc_cyc + LAT + 2);
         check("req0_ready", req0_ready, e_r0);
         check("req1_ready", req1_ready, e_r1);
         check("rsp_valid", rsp_valid, e_rv);
         check("alu_a", alu_a, m_a);
         check("alu_b", alu_b, m_b);
         check("alu_opcode", alu_opcode, m_op);
         check("done_cnt0", done_cnt0, m_cnt0);
         check("done_cnt1", done_cnt1, m_cnt1);
         if (e_rv) begin
            check("rsp_id", rsp_id, m_id);
            check("rsp_result", rsp_result, m_exp[15:0]);
            check("rsp_carryout", rsp_carryout, m_exp[17]);
            check("rsp_overflow", rsp_overflow, m_exp[16]);
            check("rsp_zero", rsp_zero, m_exp[15:0] == 16'h0);
         end
      end
      @(posedge clk);
      if (reset) begin
         m_busy = 1'b0; m_last = 1'b1; m_id = 1'b0;
         m_a = '0; m_b = '0; m_op = '0; m_cnt0 = '0; m_cnt1 = '0;
      end else begin
         if (rsp_valid && rsp_ready) begin
            obs_q.push_back(rsp_id);
            last_res = rsp_result; last_c = rsp_carryout; last_v = rsp_overflow;
            last_z = rsp_zero; last_id = rsp_id; last_lat = cyc - m_acc_cyc;
         end
         if (e_rv && rsp_ready) begin
            m_busy = 1'b0;
            if (m_id) m_cnt1 = m_cnt1 + 16'd1;
            else      m_cnt0 = m_cnt0 + 16'd1;
         end
         if (e_r0 || e_r1) begin
            m_id  = e_r1;
            m_a   = e_r1 ? req1_a  : req0_a;
            m_b   = e_r1 ? req1_b  : req0_b;
            m_op  = e_r1 ? req1_op : req0_op;
            m_exp = alu_fn(m_a, m_b, m_op);
            m_busy = 1'b1; m_last = e_r1; m_acc_cyc = cyc;
         end
      end
      cyc++;
      #1;
      if (drop_on_accept && e_r0) req0_valid = 1'b0;
      if (drop_on_accept && e_r1) req1_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
      step();
      step();
      reset = 1'b0;
      obs_q.delete();
   endtask

   task automatic w_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                       output int lat, output logic [15:0] res, output logic c, output logic v,
                       output logic z, output logic id);
      w_req0_a = a; w_req0_b = b; w_req0_op = op; w_req0_valid = 1'b1;
      @(negedge clk);
      check("w_req0_ready", w_req0_ready, 1);
      @(posedge clk); #1;
      w_req0_valid = 1'b0;
      lat = 1;
      while (!w_rsp_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      res = w_rsp_result; c = w_rsp_carryout; v = w_rsp_overflow; z = w_rsp_zero; id = w_rsp_id;
      w_rsp_ready = 1'b1;
      @(posedge clk); #1;
      w_rsp_ready = 1'b0;
   endtask

   initial begin
      int          g;
      int          lat;
      logic [15:0] r;
      logic        c, v, z, id;

      req0_a = '0; req0_b = '0; req0_op = '0; req1_a = '0; req1_b = '0; req1_op = '0;
      w_reset = 1'b1; w_req0_valid = 1'b0; w_req1_valid = 1'b0; w_rsp_ready = 1'b0;
      w_req0_a = '0; w_req0_b = '0; w_req0_op = '0; w_req1_a = '0; w_req1_b = '0; w_req1_op = '0;

      do_reset();
      w_reset = 1'b0;
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_rsp_result", rsp_result, 0);
      check("rst_rsp_carry", rsp_carryout, 0);
      check("rst_rsp_ovf", rsp_overflow, 0);
      check("rst_rsp_zero", rsp_zero, 0);
      check("rst_alu_a", alu_a, 0);
      check("rst_alu_b", alu_b, 0);
      check("rst_alu_op", alu_opcode, 0);
      check("rst_done0", done_cnt0, 0);
      check("rst_done1", done_cnt1, 0);

      // Single op with immediate response acceptance
      req0_a = 16'hFFFF; req0_b = 16'h0001; req0_op = 3'b000;
      req0_valid = 1'b1; rsp_ready = 1'b1; drop_on_accept = 1'b1;
      repeat (5) step();
      check("single_count", obs_q.size(), 1);
      check("single_lat", last_lat, 3);
      check("single_id", last_id, 0);
      check("single_res", last_res, 16'h0000);
      check("single_carry", last_c, 1);
      check("single_zero", last_z, 1);
      check("single_done0", done_cnt0, 1);

      // Simultaneous request right after reset
      do_reset();
      req0_a = 16'h1234; req0_b = 16'h4321; req0_op = 3'b000;
      req1_a = 16'h00F0; req1_b = 16'h0F0F; req1_op = 3'b100;
      req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
      repeat (12) step();
      check("simul_count", obs_q.size(), 2);
      if (obs_q.size() == 2) begin
         check("simul_first", obs_q[0], 0);
         check("simul_second", obs_q[1], 1);
      end
      check("simul_res", last_res, 16'h0000);
      check("simul_zero", last_z, 1);

      // Fairness with both requesters always pending
      do_reset();
      drop_on_accept = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
      g = 0;
      while (obs_q.size() < 6 && g < 60) begin
         req0_a = 16'($urandom); req0_b = 16'($urandom); req0_op = 3'($urandom);
         req1_a = 16'($urandom); req1_b = 16'($urandom); req1_op = 3'($urandom);
         step();
         g++;
      end
      check("fair_budget", obs_q.size(), 6);
      for (int i = 0; i < obs_q.size() && i < 6; i++) check("fair_order", obs_q[i], i % 2);
      check("fair_done0", done_cnt0, 3);
      check("fair_done1", done_cnt1, 3);

      // Backpressure for 5 cycles in RESP
      do_reset();
      drop_on_accept = 1'b1;
      req0_a = 16'($urandom); req0_b = 16'($urandom); req0_op = 3'($urandom);
      req0_valid = 1'b1; req1_valid = 1'b0; rsp_ready = 1'b0;
      g = 0;
      while (!rsp_valid && g < 10) begin step(); g++; end
      check("bp_budget", rsp_valid, 1);
      drop_on_accept = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req1_a = 16'($urandom); req1_b = 16'($urandom); req1_op = 3'($urandom);
      repeat (5) step();
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
      repeat (4) step();
      check("bp_count", obs_q.size(), 1);
      check("bp_done0", done_cnt0, 1);

      // Reset in the cycle after accept
      do_reset();
      drop_on_accept = 1'b1;
      req1_a = 16'h0003; req1_b = 16'h0004; req1_op = 3'b000;
      req1_valid = 1'b1; rsp_ready = 1'b1;
      step();
      req1_valid = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      repeat (5) step();
      check("rexec_count", obs_q.size(), 0);
      check("rexec_done0", done_cnt0, 0);
      check("rexec_done1", done_cnt1, 0);
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      check("rexec_prio0", req0_ready, 1);
      check("rexec_prio1", req1_ready, 0);
      repeat (12) step();

      // Randomized traffic, including valids dropped before grant
      drop_on_accept = 1'b0;
      for (int i = 0; i < 400; i++) begin
         req0_valid = 1'($urandom_range(0, 1));
         req1_valid = 1'($urandom_range(0, 1));
         rsp_ready  = ($urandom_range(0, 3) != 0);
         req0_a = 16'($urandom); req0_b = 16'($urandom); req0_op = 3'($urandom);
         req1_a = 16'($urandom); req1_b = 16'($urandom); req1_op = 3'($urandom);
         if (i % 7 == 0) begin
            req0_b = 16'h0000; req0_a = 16'h0000;
         end
         step();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;

      // Latency-3 instance: signed add overflow, then counter wrap
      w_op(16'h7FFF, 16'h0001, 3'b001, lat, r, c, v, z, id);
      check("w_lat", lat, 5);
      check("w_res", r, 16'h8000);
      check("w_ovf", v, 1);
      check("w_zero", z, 0);
      check("w_carry", c, 0);
      check("w_id", id, 0);
      for (int i = 0; i < 4; i++) begin
         w_op(16'($urandom), 16'($urandom), 3'($urandom), lat, r, c, v, z, id);
         check("w_lat_n", lat, 5);
      end
      check("w_wrap_done0", w_done_cnt0, 2'd1);
      check("w_done1", w_done_cnt1, 2'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
